alt_trigout_capture: RTL and testbench

//  Captures trigger events from ADC channels 1-4 and the external trigger, and timestamps each one with White Rabbit time.

---
 rtl/alt_trigout_pkg.sv | 25 ++
 rtl/alt_trigout_if.sv | 27 ++
 rtl/alt_trigout_fifo.sv | 80 ++++++++
 rtl/alt_trigout_capture.sv | 121 ++++++++++++
 tb/tb_alt_trigout_capture.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/alt_trigout_pkg.sv
// Shared types and constants for the alt_trigout capture path.
// Holds the WR timestamp field widths, the trigger source bit
// positions and the FIFO entry layout used by the capture FIFO.
package alt_trigout_pkg;

    localparam int SEC_W   = 40;   // WR seconds width
    localparam int CYC_W   = 28;   // WR 8 ns cycle counter width
    localparam int NSRC    = 5;    // number of trigger sources
    localparam int LEVEL_W = 7;    // fill level width, holds 0..64

    // Bit positions of each source inside trig_i and the entry mask
    localparam int SRC_CH1 = 0;
    localparam int SRC_CH2 = 1;
    localparam int SRC_CH3 = 2;
    localparam int SRC_CH4 = 3;
    localparam int SRC_EXT = 4;

    // One timestamped trigger event
    typedef struct packed {
        logic [SEC_W-1:0] sec;
        logic [CYC_W-1:0] cycles;
        logic [NSRC-1:0]  mask;
    } ts_entry_t;

endpackage

// File: rtl/alt_trigout_if.sv
// Register-block side of the trigger timestamp capture.
// master : CSR block - issues the pop strobe and overflow clear,
//          reads head entry, fill level and sticky overflow.
// slave  : alt_trigout_capture - serves the head entry and status.
interface alt_trigout_if;
    import alt_trigout_pkg::*;

    logic                ts_rd_i;       // 1-cycle pop strobe
    logic                ts_present_o;  // FIFO not empty
    logic [SEC_W-1:0]    ts_sec_o;      // head seconds
    logic [CYC_W-1:0]    ts_cycles_o;   // head cycles
    logic [NSRC-1:0]     ts_mask_o;     // head source mask
    logic [LEVEL_W-1:0]  level_o;       // fill level
    logic                ovf_o;         // sticky drop flag
    logic                ovf_clr_i;     // clears ovf_o

    modport master (
        output ts_rd_i, ovf_clr_i,
        input  ts_present_o, ts_sec_o, ts_cycles_o, ts_mask_o, level_o, ovf_o
    );

    modport slave (
        input  ts_rd_i, ovf_clr_i,
        output ts_present_o, ts_sec_o, ts_cycles_o, ts_mask_o, level_o, ovf_o
    );

endinterface

// File: rtl/alt_trigout_fifo.sv
// Show-ahead register FIFO of ts_entry_t.
// Ports: clk_i, rst_n_i (async, active-low, pointers only),
//        push_i/din_i write side, pop_i read side, dout_o head entry
//        (zero while empty), full_o, empty_o, level_o (0..DEPTH).
// A pop on an empty FIFO is ignored; a push on a full FIFO is only
// accepted when a pop frees the slot in the same cycle.
module alt_trigout_fifo
    import alt_trigout_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               push_i,
    input  ts_entry_t          din_i,
    input  logic               pop_i,
    output ts_entry_t          dout_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [LEVEL_W-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] diff_s;
    logic          empty_s;
    logic          full_s;
    logic          pop_eff_s;
    logic          push_eff_s;
    ts_entry_t     mem_r [DEPTH];

    // Pointers wrap modulo 2*DEPTH: equal means empty, MSB-only difference means full
    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                        (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_eff_s  = pop_i & ~empty_s;
    assign push_eff_s = push_i & (~full_s | pop_eff_s);
    assign diff_s     = wr_ptr_r - rd_ptr_r;

    assign full_o  = full_s;
    assign empty_o = empty_s;
    assign level_o = LEVEL_W'(diff_s);

    // Read/write pointer registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
        end else begin
            if (push_eff_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_eff_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Entry storage, intentionally not reset
    always_ff @(posedge clk_i) begin
        if (push_eff_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din_i;
        end
    end

    // Show-ahead head entry, forced to zero while empty
    always_comb begin
        dout_o = '0;
        if (empty_s) begin
            dout_o = '0;
        end else begin
            dout_o = mem_r[rd_ptr_r[AW-1:0]];
        end
    end

endmodule

// File: rtl/alt_trigout_capture.sv
// Trigger timestamp capture for ADC channels 1-4 and the external
// trigger. Rising edges of enabled sources are stamped with WR time
// and queued as {sec, cycles, mask}; the head entry is presented to
// the register block, and each ts_rd_i strobe pops one entry.
// Ports: clk_i, rst_n_i (async, active-low), trig_i[4:0] (ch4..ch1,
//        ext at bit 4), ch_enable_i, ext_enable_i, tm_valid_i,
//        tm_sec_i, tm_cycles_i, csr (alt_trigout_if.slave).
// Build option: define TRIGOUT_HOLDOFF_EN to mask new captures for
// HOLDOFF_CYC cycles after each accepted capture.
module alt_trigout_capture
    import alt_trigout_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int HOLDOFF_CYC = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [NSRC-1:0]  trig_i,
    input  logic [3:0]       ch_enable_i,
    input  logic             ext_enable_i,
    input  logic             tm_valid_i,
    input  logic [SEC_W-1:0] tm_sec_i,
    input  logic [CYC_W-1:0] tm_cycles_i,
    alt_trigout_if.slave     csr
);

    if ((DEPTH < 2) || (DEPTH > 64) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_bad
        $error("alt_trigout_capture: DEPTH must be a power of 2 in 2..64");
    end
    if (HOLDOFF_CYC < 1) begin : g_holdoff_bad
        $error("alt_trigout_capture: HOLDOFF_CYC must be at least 1");
    end

    logic [NSRC-1:0] trig_d_r;
    logic [NSRC-1:0] enable_s;
    logic [NSRC-1:0] rise_raw_s;
    logic [NSRC-1:0] rise_s;
    logic            capture_s;
    logic            drop_s;
    logic            push_s;
    logic            full_s;
    logic            empty_s;
    logic            ovf_r;
    ts_entry_t       new_entry_s;
    ts_entry_t       head_s;

    assign enable_s[SRC_CH4:SRC_CH1] = ch_enable_i;
    assign enable_s[SRC_EXT]         = ext_enable_i;
    assign rise_raw_s                = trig_i & ~trig_d_r & enable_s;

    // Trigger history for edge detection; keeps tracking during holdoff
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            trig_d_r <= {NSRC{1'b0}};
        end else begin
            trig_d_r <= trig_i;
        end
    end

`ifdef TRIGOUT_HOLDOFF_EN
    localparam int HW = $clog2(HOLDOFF_CYC) + 1;
    logic [HW-1:0] holdoff_r;

    // Masked edges are discarded outright, so they never count as drops
    assign rise_s = (holdoff_r != {HW{1'b0}}) ? {NSRC{1'b0}} : rise_raw_s;

    // Holdoff counter: reloads on every accepted capture, then counts down to zero
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            holdoff_r <= {HW{1'b0}};
        end else if (push_s) begin
            holdoff_r <= HW'(HOLDOFF_CYC - 1);
        end else if (holdoff_r != {HW{1'b0}}) begin
            holdoff_r <= holdoff_r - {{(HW-1){1'b0}}, 1'b1};
        end
    end
`else
    assign rise_s = rise_raw_s;
`endif

    // A full FIFO still accepts an event when the CSR pops in the same cycle
    assign capture_s = |rise_s;
    assign drop_s    = capture_s & (~tm_valid_i | (full_s & ~(csr.ts_rd_i & ~empty_s)));
    assign push_s    = capture_s & ~drop_s;

    assign new_entry_s.sec    = tm_sec_i;
    assign new_entry_s.cycles = tm_cycles_i;
    assign new_entry_s.mask   = rise_s;

    alt_trigout_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push_s),
        .din_i   (new_entry_s),
        .pop_i   (csr.ts_rd_i),
        .dout_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .level_o (csr.level_o)
    );

    // Sticky overflow flag; a drop in the same cycle as a clear wins
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (csr.ovf_clr_i) begin
            ovf_r <= 1'b0;
        end
    end

    assign csr.ovf_o        = ovf_r;
    assign csr.ts_present_o = ~empty_s;
    assign csr.ts_sec_o     = head_s.sec;
    assign csr.ts_cycles_o  = head_s.cycles;
    assign csr.ts_mask_o    = head_s.mask;

endmodule

// File: tb/tb_alt_trigout_capture.sv
// Directed self-checking bench for alt_trigout_capture (DEPTH=8).
module tb_alt_trigout_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  trig;
    logic [3:0]  ch_en;
    logic        ext_en;
    logic        tm_valid;
    logic [39:0] tm_sec;
    logic [27:0] tm_cyc;
    int          n_checks = 0;
    int          n_pass   = 0;

    alt_trigout_if bus ();

    alt_trigout_capture #(
        .DEPTH       (8),
        .HOLDOFF_CYC (16)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .trig_i       (trig),
        .ch_enable_i  (ch_en),
        .ext_enable_i (ext_en),
        .tm_valid_i   (tm_valid),
        .tm_sec_i     (tm_sec),
        .tm_cycles_i  (tm_cyc),
        .csr          (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic event_pulse(input logic [4:0] t);
        trig = t;
        tick();
        trig = 5'b00000;
        tick();
`ifdef TRIGOUT_HOLDOFF_EN
        repeat (16) tick();
`endif
    endtask

    task automatic pop_one();
        bus.ts_rd_i = 1'b1;
        tick();
        bus.ts_rd_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; trig = 5'b0; ch_en = 4'b0; ext_en = 1'b0; tm_valid = 1'b0;
        tm_sec = 40'h0; tm_cyc = 28'h0; bus.ts_rd_i = 1'b0; bus.ovf_clr_i = 1'b0;
        tick(); tick();
        n_checks++; if (bus.ts_present_o !== 1'b0) $display("FAIL reset_present got %0h exp 0", bus.ts_present_o); else n_pass++;
        n_checks++; if (bus.level_o !== 7'd0) $display("FAIL reset_level got %0d exp 0", bus.level_o); else n_pass++;
        n_checks++; if (bus.ovf_o !== 1'b0) $display("FAIL reset_ovf got %0h exp 0", bus.ovf_o); else n_pass++;
        n_checks++; if (bus.ts_sec_o !== 40'h0 || bus.ts_mask_o !== 5'h0) $display("FAIL reset_head got sec %0h mask %0h exp 0", bus.ts_sec_o, bus.ts_mask_o); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        ch_en = 4'b0001; tm_valid = 1'b1; tm_sec = 40'h12; tm_cyc = 28'h100;
        trig = 5'b00001;
        tick();
        trig = 5'b00000;
        n_checks++; if (bus.ts_present_o !== 1'b1) $display("FAIL single_present got %0h exp 1", bus.ts_present_o); else n_pass++;
        n_checks++; if (bus.ts_sec_o !== 40'h12 || bus.ts_cycles_o !== 28'h100) $display("FAIL single_time got %0h/%0h exp 12/100", bus.ts_sec_o, bus.ts_cycles_o); else n_pass++;
        n_checks++; if (bus.ts_mask_o !== 5'b00001) $display("FAIL single_mask got %b exp 00001", bus.ts_mask_o); else n_pass++;
        pop_one();
        n_checks++; if (bus.ts_present_o !== 1'b0 || bus.level_o !== 7'd0) $display("FAIL single_pop got present %0h level %0d exp 0/0", bus.ts_present_o, bus.level_o); else n_pass++;
        tick();
    endtask

    task automatic test_coincidence();
        ch_en = 4'b1111; ext_en = 1'b1; tm_sec = 40'h20; tm_cyc = 28'h200;
        event_pulse(5'b10011);
        n_checks++; if (bus.level_o !== 7'd1) $display("FAIL coinc_level got %0d exp 1", bus.level_o); else n_pass++;
        n_checks++; if (bus.ts_mask_o !== 5'b10011) $display("FAIL coinc_mask got %b exp 10011", bus.ts_mask_o); else n_pass++;
        pop_one();
        ch_en = 4'b1101;
        event_pulse(5'b00010);
        n_checks++; if (bus.level_o !== 7'd0 || bus.ts_present_o !== 1'b0) $display("FAIL disabled_ch got level %0d present %0h exp 0/0", bus.level_o, bus.ts_present_o); else n_pass++;
        n_checks++; if (bus.ovf_o !== 1'b0) $display("FAIL disabled_ovf got %0h exp 0", bus.ovf_o); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [39:0] exp_sec [8];
        exp_sec = '{40'd2, 40'd3, 40'd4, 40'd5, 40'd6, 40'd7, 40'd8, 40'd10};
        ch_en = 4'b0001; ext_en = 1'b0; tm_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tm_sec = 40'(i); tm_cyc = 28'(i * 16);
            event_pulse(5'b00001);
        end
        n_checks++; if (bus.level_o !== 7'd8 || bus.ovf_o !== 1'b0) $display("FAIL fill8 got level %0d ovf %0h exp 8/0", bus.level_o, bus.ovf_o); else n_pass++;
        tm_sec = 40'd9; tm_cyc = 28'd144;
        event_pulse(5'b00001);
        n_checks++; if (bus.level_o !== 7'd8 || bus.ovf_o !== 1'b1) $display("FAIL ovf9 got level %0d ovf %0h exp 8/1", bus.level_o, bus.ovf_o); else n_pass++;
        n_checks++; if (bus.ts_sec_o !== 40'd1 || bus.ts_cycles_o !== 28'd16) $display("FAIL ovf_head got %0h/%0h exp 1/10", bus.ts_sec_o, bus.ts_cycles_o); else n_pass++;
        bus.ovf_clr_i = 1'b1; tick(); bus.ovf_clr_i = 1'b0;
        n_checks++; if (bus.ovf_o !== 1'b0) $display("FAIL ovf_clr got %0h exp 0", bus.ovf_o); else n_pass++;
        tm_sec = 40'd10; tm_cyc = 28'd160;
        trig = 5'b00001; bus.ts_rd_i = 1'b1;
        tick();
        trig = 5'b00000; bus.ts_rd_i = 1'b0;
        tick();
        n_checks++; if (bus.level_o !== 7'd8 || bus.ovf_o !== 1'b0) $display("FAIL full_pushpop got level %0d ovf %0h exp 8/0", bus.level_o, bus.ovf_o); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (bus.ts_sec_o !== exp_sec[k]) $display("FAIL drain_order[%0d] got %0d exp %0d", k, bus.ts_sec_o, exp_sec[k]); else n_pass++;
            pop_one();
        end
        n_checks++; if (bus.ts_present_o !== 1'b0 || bus.level_o !== 7'd0) $display("FAIL drain_empty got present %0h level %0d exp 0/0", bus.ts_present_o, bus.level_o); else n_pass++;
    endtask

    task automatic test_invalid_time();
        ch_en = 4'b0001; tm_valid = 1'b0;
        event_pulse(5'b00001);
        n_checks++; if (bus.level_o !== 7'd0 || bus.ovf_o !== 1'b1) $display("FAIL invalid_time got level %0d ovf %0h exp 0/1", bus.level_o, bus.ovf_o); else n_pass++;
        trig = 5'b00001; bus.ovf_clr_i = 1'b1;
        tick();
        trig = 5'b00000; bus.ovf_clr_i = 1'b0;
        n_checks++; if (bus.ovf_o !== 1'b1) $display("FAIL ovf_set_wins got %0h exp 1", bus.ovf_o); else n_pass++;
        tick();
        bus.ovf_clr_i = 1'b1; tick(); bus.ovf_clr_i = 1'b0;
        n_checks++; if (bus.ovf_o !== 1'b0) $display("FAIL invalid_clr got %0h exp 0", bus.ovf_o); else n_pass++;
        tm_valid = 1'b1;
    endtask

    task automatic test_reset_mid();
        ch_en = 4'b0001; tm_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tm_sec = 40'(i + 32);
            event_pulse(5'b00001);
        end
        tm_valid = 1'b0;
        event_pulse(5'b00001);
        tm_valid = 1'b1;
        n_checks++; if (bus.level_o !== 7'd3 || bus.ovf_o !== 1'b1) $display("FAIL premid got level %0d ovf %0h exp 3/1", bus.level_o, bus.ovf_o); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.level_o !== 7'd0 || bus.ts_present_o !== 1'b0) $display("FAIL async_rst got level %0d present %0h exp 0/0", bus.level_o, bus.ts_present_o); else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.level_o !== 7'd0 || bus.ts_present_o !== 1'b0 || bus.ovf_o !== 1'b0) $display("FAIL post_rst got level %0d present %0h ovf %0h exp 0/0/0", bus.level_o, bus.ts_present_o, bus.ovf_o); else n_pass++;
        tm_sec = 40'h55; tm_cyc = 28'h555;
        event_pulse(5'b00001);
        n_checks++; if (bus.level_o !== 7'd1 || bus.ts_sec_o !== 40'h55 || bus.ts_cycles_o !== 28'h555) $display("FAIL after_rst got level %0d sec %0h cyc %0h exp 1/55/555", bus.level_o, bus.ts_sec_o, bus.ts_cycles_o); else n_pass++;
        pop_one();
    endtask

    task automatic test_back_to_back();
        ch_en = 4'b1111; ext_en = 1'b1; tm_valid = 1'b1;
        pop_one();
        n_checks++; if (bus.level_o !== 7'd0 || bus.ts_present_o !== 1'b0) $display("FAIL empty_pop got level %0d present %0h exp 0/0", bus.level_o, bus.ts_present_o); else n_pass++;
        tm_sec = 40'h70; trig = 5'b00001; bus.ts_rd_i = 1'b1;
        tick();
        bus.ts_rd_i = 1'b0;
        n_checks++; if (bus.level_o !== 7'd1) $display("FAIL empty_pushpop got level %0d exp 1", bus.level_o); else n_pass++;
        tm_sec = 40'h71; trig = 5'b00011;
        tick();
        trig = 5'b00000;
        tick();
        n_checks++; if (bus.level_o !== 7'd2) $display("FAIL b2b_level got %0d exp 2", bus.level_o); else n_pass++;
        n_checks++; if (bus.ts_mask_o !== 5'b00001 || bus.ts_sec_o !== 40'h70) $display("FAIL b2b_first got mask %b sec %0h exp 00001/70", bus.ts_mask_o, bus.ts_sec_o); else n_pass++;
        pop_one();
        n_checks++; if (bus.ts_mask_o !== 5'b00010 || bus.ts_sec_o !== 40'h71) $display("FAIL b2b_second got mask %b sec %0h exp 00010/71", bus.ts_mask_o, bus.ts_sec_o); else n_pass++;
        pop_one();
        n_checks++; if (bus.ts_present_o !== 1'b0) $display("FAIL b2b_empty got %0h exp 0", bus.ts_present_o); else n_pass++;
    endtask

`ifdef TRIGOUT_HOLDOFF_EN
    task automatic test_holdoff();
        ch_en = 4'b0001; ext_en = 1'b0; tm_valid = 1'b1;
        repeat (20) tick();
        for (int c = 0; c < 32; c++) begin
            tm_sec = 40'(c);
            trig = ((c % 4) == 0) ? 5'b00001 : 5'b00000;
            tick();
        end
        trig = 5'b00000;
        tick();
        n_checks++; if (bus.level_o !== 7'd2 || bus.ovf_o !== 1'b0) $display("FAIL holdoff_count got level %0d ovf %0h exp 2/0", bus.level_o, bus.ovf_o); else n_pass++;
        n_checks++; if (bus.ts_sec_o !== 40'd0) $display("FAIL holdoff_first got %0d exp 0", bus.ts_sec_o); else n_pass++;
        pop_one();
        n_checks++; if (bus.ts_sec_o !== 40'd16) $display("FAIL holdoff_second got %0d exp 16", bus.ts_sec_o); else n_pass++;
        pop_one();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_coincidence();
`ifdef TRIGOUT_HOLDOFF_EN
        test_holdoff();
`else
        test_overflow();
        test_invalid_time();
        test_reset_mid();
        test_back_to_back();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
